// File: rtl/button_bounce_gen.sv
// Push-button emulator: turns press/release strobes into an active-low pin
// waveform with LFSR-timed contact bounce, followed by a settled hold period.
module button_bounce_gen #(
   parameter int          BOUNCE_CNT = 3,
   parameter int          GAP_W      = 3,
   parameter int          SETTLE     = 16,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic press_i,
   input  logic release_i,
   output logic btn_o,
   output logic busy_o,
   output logic pressed_o,
   output logic done_o
);

   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam int          SET_W    = $clog2(SETTLE + 1);
   localparam int          CNT_W    = (GAP_W + 1 > SET_W) ? GAP_W + 1 : SET_W;
   localparam logic [4:0]  EDGES    = 5'(2 * BOUNCE_CNT);
   localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BOUNCE,
      S_SETTLE
   } state_t;

   state_t           state_reg;
   logic [15:0]      lfsr_reg;
   logic             lfsr_fb;
   logic             target_reg;
   logic [4:0]       edges_left_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] gap_val;
   logic             accept_press;
   logic             accept_release;

   // x^16 + x^14 + x^13 + x^11 + 1
   assign lfsr_fb        = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
   assign gap_val        = CNT_W'(lfsr_reg[GAP_W-1:0]) + CNT_W'(1);
   assign accept_press   = press_i & ~pressed_o;
   assign accept_release = release_i & pressed_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg      <= S_IDLE;
         lfsr_reg       <= SEED_EFF;
         target_reg     <= 1'b1;
         edges_left_reg <= '0;
         cnt_reg        <= '0;
         btn_o          <= 1'b1;
         busy_o         <= 1'b0;
         pressed_o      <= 1'b0;
         done_o         <= 1'b0;
      end else begin
         lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
         done_o   <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               // At most one of the two accepts can be true, chosen by pressed_o.
               if (accept_press || accept_release) begin
                  target_reg     <= accept_release;
                  btn_o          <= accept_release;
                  busy_o         <= 1'b1;
                  edges_left_reg <= EDGES;
                  if (EDGES != 5'd0) begin
                     state_reg <= S_BOUNCE;
                     cnt_reg   <= gap_val;
                  end else begin
                     state_reg <= S_SETTLE;
                     cnt_reg   <= SETTLE_C;
                  end
               end
            end
            S_BOUNCE: begin
               if (cnt_reg > CNT_W'(1)) begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end else begin
                  btn_o          <= ~btn_o;
                  edges_left_reg <= edges_left_reg - 5'd1;
                  if (edges_left_reg == 5'd1) begin
                     state_reg <= S_SETTLE;
                     cnt_reg   <= SETTLE_C;
                  end else begin
                     cnt_reg <= gap_val;
                  end
               end
            end
            S_SETTLE: begin
               if (cnt_reg > CNT_W'(1)) begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end else begin
                  done_o    <= 1'b1;
                  pressed_o <= ~target_reg;
                  busy_o    <= 1'b0;
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Directed bench for button_bounce_gen: default-parameter instance for bounce
// behaviour and a BOUNCE_CNT=0/SETTLE=4 instance for the clean-edge timing.
module tb_button_bounce_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic press_s = 1'b0, release_s = 1'b0;
   logic press0 = 1'b0, release0 = 1'b0;
   logic btn, busy, pressed, done;
   logic btn0, busy0, pressed0, done0;

   always #5 clk = ~clk;

   button_bounce_gen dut (
      .clk_i(clk), .rst_i(rst), .press_i(press_s), .release_i(release_s),
      .btn_o(btn), .busy_o(busy), .pressed_o(pressed), .done_o(done)
   );

   button_bounce_gen #(.BOUNCE_CNT(0), .SETTLE(4)) dut0 (
      .clk_i(clk), .rst_i(rst), .press_i(press0), .release_i(release0),
      .btn_o(btn0), .busy_o(busy0), .pressed_o(pressed0), .done_o(done0)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int pstrobes = 0;
   logic [15:0] lfsr_m;
   logic s1 = 1'b1, s2 = 1'b1, s3 = 1'b1;
   int edge_times[$];
   int ref_times[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Reference LFSR from the polynomial x^16+x^14+x^13+x^11+1.
   always @(posedge clk) begin
      if (rst) lfsr_m <= 16'hACE1;
      else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   // Downstream synchronizer + falling-edge detector counting press strobes.
   always @(posedge clk) begin
      s1 <= btn; s2 <= s1; s3 <= s2;
      if (s3 && !s2) pstrobes <= pstrobes + 1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reset with press held, then idle with one ignored release strobe.
   task automatic reset_and_idle();
      rst = 1'b1; press_s = 1'b1;
      repeat (3) tick();
      chk("rst_btn", btn, 1); chk("rst_busy", busy, 0);
      chk("rst_pressed", pressed, 0); chk("rst_done", done, 0);
      rst = 1'b0; press_s = 1'b0; release_s = 1'b1;
      tick();
      release_s = 1'b0;
      chk("ign_rel_btn", btn, 1); chk("ign_rel_busy", busy, 0);
      repeat (4) tick();
      chk("ign_rel_btn_late", btn, 1);
      $display("reset+ignored release: btn=%0d busy=%0d pressed=%0d", btn, busy, pressed);
   endtask

   task automatic bounce_trans(input string tag, input logic tgt, input logic prs,
                               input logic rel, input bit inject);
      int falls, rises, since, exp_gap, left, strobe0;
      bit done_seen, gap_ok;
      logic prev_btn;
      logic [15:0] lv;
      strobe0 = pstrobes;
      lv = lfsr_m;
      press_s = prs; release_s = rel;
      tick();
      press_s = 1'b0; release_s = 1'b0;
      chk({tag, "_accept_btn"}, btn, tgt);
      chk({tag, "_accept_busy"}, busy, 1);
      edge_times.delete();
      edge_times.push_back(cyc);
      falls = (tgt == 1'b0) ? 1 : 0;
      rises = (tgt == 1'b1) ? 1 : 0;
      exp_gap = int'(lv[2:0]) + 1;
      left = 6; since = 0; gap_ok = 1'b1; done_seen = 1'b0;
      prev_btn = btn;
      for (int n = 0; n < 300 && !done_seen; n++) begin
         lv = lfsr_m;
         if (inject && n == 1) press_s = 1'b1;
         tick();
         press_s = 1'b0;
         since++;
         if (btn != prev_btn) begin
            edge_times.push_back(cyc);
            if (since != exp_gap) gap_ok = 1'b0;
            if (btn == 1'b0) falls++; else rises++;
            left--;
            since = 0;
            exp_gap = int'(lv[2:0]) + 1;
            prev_btn = btn;
         end
         if (done) done_seen = 1'b1;
      end
      chk({tag, "_done_seen"}, int'(done_seen), 1);
      chk({tag, "_settle_cycles"}, since, 16);
      chk({tag, "_gaps"}, int'(gap_ok), 1);
      chk({tag, "_edges_left"}, left, 0);
      chk({tag, "_falls"}, falls, (tgt == 1'b0) ? 4 : 3);
      chk({tag, "_rises"}, rises, (tgt == 1'b0) ? 3 : 4);
      chk({tag, "_final_btn"}, btn, tgt);
      chk({tag, "_pressed"}, pressed, (tgt == 1'b0) ? 1 : 0);
      chk({tag, "_busy_clear"}, busy, 0);
      chk({tag, "_strobes"}, pstrobes - strobe0, (tgt == 1'b0) ? 4 : 3);
      $display("%s: falls=%0d rises=%0d edges=%0d settle=%0d done=%0d",
               tag, falls, rises, edge_times.size(), since, done_seen);
   endtask

   initial begin
      @(negedge clk);
      reset_and_idle();

      // Bounced press with a stray press during bounce, then back-to-back release.
      bounce_trans("press1", 1'b0, 1'b1, 1'b0, 1'b1);
      ref_times = edge_times;
      bounce_trans("release1", 1'b1, 1'b0, 1'b1, 1'b0);
      bounce_trans("both_press", 1'b0, 1'b1, 1'b1, 1'b0);
      bounce_trans("release2", 1'b1, 1'b0, 1'b1, 1'b0);

      // Clean edge instance: done after N+4, back-to-back release in done cycle.
      press0 = 1'b1;
      tick();
      press0 = 1'b0;
      chk("clean_btn", btn0, 0); chk("clean_busy", busy0, 1); chk("clean_done_early", done0, 0);
      repeat (3) tick();
      chk("clean_done_n3", done0, 0);
      tick();
      chk("clean_done", done0, 1); chk("clean_pressed", pressed0, 1); chk("clean_busy_clr", busy0, 0);
      $display("clean press: btn0=%0d done0=%0d pressed0=%0d", btn0, done0, pressed0);
      release0 = 1'b1;
      tick();
      release0 = 1'b0;
      chk("clean_rel_btn", btn0, 1); chk("clean_rel_busy", busy0, 1); chk("clean_rel_pressed", pressed0, 1);
      repeat (4) tick();
      chk("clean_rel_done", done0, 1); chk("clean_rel_pressed_upd", pressed0, 0);
      $display("clean release: btn0=%0d done0=%0d pressed0=%0d", btn0, done0, pressed0);

      // Mid-operation reset during bounce.
      reset_and_idle();
      press_s = 1'b1;
      tick();
      press_s = 1'b0;
      repeat (2) tick();
      chk("mid_busy_before", busy, 1);
      rst = 1'b1;
      tick();
      chk("mid_rst_btn", btn, 1); chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0); chk("mid_rst_pressed", pressed, 0);
      $display("mid-op reset: btn=%0d busy=%0d done=%0d", btn, busy, done);

      // Same stimulus from reset must reproduce the first run's edge timing.
      reset_and_idle();
      bounce_trans("press2", 1'b0, 1'b1, 1'b0, 1'b1);
      chk("determ_len", edge_times.size(), ref_times.size());
      if (edge_times.size() == ref_times.size()) begin
         for (int i = 1; i < edge_times.size(); i++)
            chk($sformatf("determ_edge%0d", i), edge_times[i] - edge_times[0],
                ref_times[i] - ref_times[0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
